lsu_mem_responder: RTL and testbench

Behavioural memory endpoint that answers the LSU's memory-side request/response channel in allocator simulations. It accepts one request at a time: read, write, or compare-and-swap. It applies the request to an internal word array and returns exactly one response beat after a programmable latency. Allocator test benches instantiate it to close the loop behind the LSU.

---
 rtl/allocator_pkg.sv | 27 ++
 rtl/mem_resp_array.sv | 29 ++
 rtl/lsu_mem_responder.sv | 121 ++++++++++++
 tb/tb_lsu_mem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/allocator_pkg.sv
// Shared types for the allocator memory-side channel: request/response beats,
// CAS status codes and the responder state encoding.
package allocator_pkg;

  localparam int DATA_W = 64;

  localparam logic [DATA_W-1:0] CAS_OK   = DATA_W'(1);
  localparam logic [DATA_W-1:0] CAS_FAIL = DATA_W'(0);

  typedef struct packed {
    logic              is_write;
    logic              is_cas;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } mem_rsp_t;

  typedef enum logic [1:0] {
    MR_IDLE,
    MR_WAIT,
    MR_RESP
  } mem_rsp_state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Word array for the memory responder: combinational read, one synchronous write
// port, whole array cleared by the asynchronous reset.
module mem_resp_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/lsu_mem_responder.sv
// Behavioural memory endpoint behind the LSU: one read/write/CAS at a time, response
// after LATENCY cycles, held until mem_rsp_rdy_i; no new request accepted until then.
module lsu_mem_responder #(
  parameter int DATA_W    = allocator_pkg::DATA_W,
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  input  logic              mem_req_is_cas_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o
);

  import allocator_pkg::*;

  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam int         OFF      = $clog2(DATA_W / 8);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  mem_req_t          req;
  mem_rsp_t          rsp_d, rsp_q;
  mem_rsp_state_e    state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;
  logic              link_val_q;
  logic [IDX_W-1:0]  link_idx_q;
  logic [DATA_W-1:0] link_data_q;
  logic              cas_ok;
  logic              wr_en;
  logic              unused_addr_bits;

  assign req = '{is_write: mem_req_is_write_i, is_cas: mem_req_is_cas_i,
                 addr: mem_req_addr_i, data: mem_req_data_i};

  // Sub-word offset and bits above the array size are ignored, so addresses wrap.
  assign idx              = req.addr[OFF +: IDX_W];
  assign unused_addr_bits = ^{req.addr[OFF-1:0], req.addr[DATA_W-1:OFF+IDX_W]};

  assign mem_req_rdy_o  = (state_q == MR_IDLE);
  assign mem_rsp_val_o  = (state_q == MR_RESP);
  assign mem_rsp_data_o = rsp_q.data;
  assign accept         = mem_req_val_i & mem_req_rdy_o;

  assign cas_ok = link_val_q && (link_idx_q == idx) && (rd_data == link_data_q);
  assign wr_en  = accept && req.is_write && (!req.is_cas || cas_ok);

  mem_resp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .rd_idx  (idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (req.data)
  );

  always_comb begin
    rsp_d.data = '0;
    if (!req.is_write)    rsp_d.data = rd_data;
    else if (req.is_cas)  rsp_d.data = cas_ok ? CAS_OK : CAS_FAIL;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MR_IDLE: if (accept) begin
        cnt_d   = CNT_INIT;
        state_d = (LATENCY == 1) ? MR_RESP : MR_WAIT;
      end
      MR_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = MR_RESP;
      end
      MR_RESP: if (mem_rsp_rdy_i) state_d = MR_IDLE;
      default: state_d = MR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Link register and response capture commit on the acceptance edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q       <= '0;
      link_val_q  <= 1'b0;
      link_idx_q  <= '0;
      link_data_q <= '0;
    end else if (accept) begin
      rsp_q <= rsp_d;
      if (!req.is_write) begin
        link_val_q  <= 1'b1;
        link_idx_q  <= idx;
        link_data_q <= rd_data;
      end else if (req.is_cas || (link_idx_q == idx)) begin
        link_val_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Randomized and directed checks of lsu_mem_responder against a word-array/link
// reference model: response values, latency, stall hold, aliasing and async reset.
module tb_lsu_mem_responder;

  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_val, req_rdy, req_w, req_c;
  logic [DW-1:0] req_addr, req_data;
  logic          rsp_val, rsp_rdy;
  logic [DW-1:0] rsp_data;

  always #5 clk = ~clk;

  lsu_mem_responder #(
    .DATA_W    (DW),
    .MEM_DEPTH (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .mem_req_val_i      (req_val),
    .mem_req_rdy_o      (req_rdy),
    .mem_req_is_write_i (req_w),
    .mem_req_addr_i     (req_addr),
    .mem_req_data_i     (req_data),
    .mem_req_is_cas_i   (req_c),
    .mem_rsp_val_o      (rsp_val),
    .mem_rsp_rdy_i      (rsp_rdy),
    .mem_rsp_data_o     (rsp_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain word array plus a load-link record.
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_link;
  int            mdl_lidx;
  logic [DW-1:0] mdl_ldata;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    mdl_link  = 1'b0;
    mdl_lidx  = 0;
    mdl_ldata = '0;
  endtask

  task automatic model_op(input logic w, input logic c, input logic [DW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] r);
    int i;
    bit ok;
    i = int'((a / (DW / 8)) % DEPTH);
    r = '0;
    if (!w) begin
      r         = mdl_mem[i];
      mdl_link  = 1'b1;
      mdl_lidx  = i;
      mdl_ldata = mdl_mem[i];
    end else if (!c) begin
      mdl_mem[i] = d;
      if (mdl_lidx == i) mdl_link = 1'b0;
    end else begin
      ok = mdl_link && (mdl_lidx == i) && (mdl_mem[i] == mdl_ldata);
      if (ok) mdl_mem[i] = d;
      mdl_link = 1'b0;
      r = ok ? 64'd1 : 64'd0;
    end
  endtask

  // Inputs are don't-care while the responder is busy, so scramble them.
  task automatic drive_junk();
    req_val  = 1'($urandom_range(0, 1));
    req_w    = 1'($urandom_range(0, 1));
    req_c    = 1'($urandom_range(0, 1));
    req_addr = {$urandom, $urandom};
    req_data = {$urandom, $urandom};
  endtask

  task automatic xact(input logic w, input logic c, input logic [DW-1:0] a,
                      input logic [DW-1:0] d, input int stall, output logic [DW-1:0] got);
    logic [DW-1:0] exp;
    int lat;
    @(negedge clk);
    check("req_rdy_idle", 64'(req_rdy), 64'd1);
    req_val  = 1'b1;
    req_w    = w;
    req_c    = c;
    req_addr = a;
    req_data = d;
    @(posedge clk);
    model_op(w, c, a, d, exp);
    #1 drive_junk();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_val) drive_junk();
    end while (!rsp_val && lat < LAT + 8);
    check("rsp_latency", 64'(lat), 64'(LAT));
    got = rsp_data;
    check("rsp_data", got, exp);
    check("req_rdy_busy", 64'(req_rdy), 64'd0);
    for (int s = 0; s < stall; s++) begin
      drive_junk();
      @(negedge clk);
      check("rsp_val_hold", 64'(rsp_val), 64'd1);
      check("rsp_data_hold", rsp_data, exp);
      check("req_rdy_stall", 64'(req_rdy), 64'd0);
    end
    req_val = 1'b0;
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
    @(negedge clk);
    check("req_rdy_after_hs", 64'(req_rdy), 64'd1);
    check("rsp_val_after_hs", 64'(rsp_val), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] r;
    logic [DW-1:0] a;
    int kind;

    req_val = 1'b0; req_w = 1'b0; req_c = 1'b0;
    req_addr = '0; req_data = '0; rsp_rdy = 1'b0;
    model_reset();
    #12;
    check("reset_req_rdy", 64'(req_rdy), 64'd1);
    check("reset_rsp_val", 64'(rsp_val), 64'd0);
    check("reset_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain write then read back.
    xact(1'b1, 1'b0, 64'h40, 64'hDEAD, 0, r);  check("wr_rsp_zero", r, 64'd0);
    xact(1'b0, 1'b0, 64'h40, 64'h0, 0, r);     check("rd_dead", r, 64'hDEAD);

    // Successful CAS after a read.
    xact(1'b0, 1'b0, 64'h80, 64'h0, 0, r);     check("rd_80_zero", r, 64'd0);
    xact(1'b1, 1'b1, 64'h80, 64'h1234, 0, r);  check("cas_ok", r, 64'd1);
    xact(1'b0, 1'b0, 64'h80, 64'h0, 0, r);     check("rd_after_cas", r, 64'h1234);

    // Intervening plain write breaks the link.
    xact(1'b1, 1'b0, 64'h80, 64'd5, 0, r);
    xact(1'b1, 1'b1, 64'h80, 64'd7, 0, r);     check("cas_broken_link", r, 64'd0);
    xact(1'b0, 1'b0, 64'h80, 64'h0, 0, r);     check("rd_after_fail", r, 64'd5);

    // CAS to a non-linked index, then CAS with no live link.
    xact(1'b1, 1'b1, 64'h100, 64'd9, 0, r);    check("cas_other_idx", r, 64'd0);
    xact(1'b1, 1'b1, 64'h80, 64'd9, 0, r);     check("cas_no_link", r, 64'd0);
    xact(1'b0, 1'b0, 64'h80, 64'h0, 0, r);     check("rd_80_unchanged", r, 64'd5);
    xact(1'b0, 1'b0, 64'h100, 64'h0, 0, r);    check("rd_100_unchanged", r, 64'd0);

    // Response held through a long stall.
    xact(1'b0, 1'b0, 64'h40, 64'h0, 10, r);    check("rd_stalled", r, 64'hDEAD);

    // Address aliasing and ignored low bits.
    xact(1'b1, 1'b0, 64'h40 + 64'(DEPTH * DW / 8), 64'hBEEF, 0, r);
    xact(1'b0, 1'b0, 64'h40, 64'h0, 0, r);     check("rd_alias", r, 64'hBEEF);
    xact(1'b0, 1'b0, 64'h47, 64'h0, 0, r);     check("rd_low_bits", r, 64'hBEEF);

    // Random mix over a few hot words so links and CAS races actually occur.
    for (int n = 0; n < 150; n++) begin
      a = ({$urandom, $urandom} << 13) | 64'($urandom_range(0, 7) << 3) | 64'($urandom_range(0, 7));
      kind = $urandom_range(0, 2);
      xact(kind != 0, kind == 2, a, {$urandom, $urandom}, $urandom_range(0, 3), r);
    end

    // Asynchronous reset while a read is waiting for its latency.
    @(negedge clk);
    req_val = 1'b1; req_w = 1'b0; req_c = 1'b0; req_addr = 64'h40;
    @(posedge clk);
    #1 req_val = 1'b0;
    #2;
    check("busy_before_reset", 64'(req_rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_val", 64'(rsp_val), 64'd0);
    check("rst_req_rdy", 64'(req_rdy), 64'd1);
    check("rst_rsp_data", rsp_data, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    xact(1'b1, 1'b1, 64'h40, 64'h55, 0, r);    check("cas_after_reset", r, 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      xact(1'b0, 1'b0, 64'(i * (DW / 8)), 64'h0, 0, r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
